regfile_wr_arb: RTL and testbench

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rr_pick.sv | 27 ++
 rtl/regfile_wr_arb.sv | 152 +++++++++++++++
 tb/tb_regfile_wr_arb.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file write arbiter.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   // Round-robin successor of a requester index.
   function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int n);
      return 2'((int'(idx) + 1) % n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first valid requester at or after ptr_i wins.
module rr_pick #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [1:0]         ptr_i,
   output logic [NUM_REQ-1:0] grant_o
);

   // Walk the distances from ptr_i in order and grant the first valid hit.
   always_comb begin
      logic found;
      grant_o = '0;
      found   = 1'b0;
      for (int d = 0; d < NUM_REQ; d++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && valid_i[j] && (j == (int'(ptr_i) + d) % NUM_REQ)) begin
               grant_o[j] = 1'b1;
               found      = 1'b1;
            end else begin
               grant_o[j] = grant_o[j];
            end
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write arbiter: round-robin with locked bursts and a
// one-cycle registered write port.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int BURST_MAX = 4,
   parameter int DROP_ZERO = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_lock,
   input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*REG_DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           stall,
   output logic [REG_ADDR_W-1:0]          WriteAddr,
   output logic [REG_DATA_W-1:0]          WriteData,
   output logic                           RegWrite,
   output logic [1:0]                     grant_id
);

   localparam int              CNT_W   = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

   arb_state_e              state_q, state_d;
   logic [1:0]              owner_q, owner_d;
   logic [1:0]              rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
   logic [NUM_REQ-1:0]      pick_s;
   logic [NUM_REQ-1:0]      owner_mask_s;
   logic                    accept_s;
   logic [1:0]              acc_idx_s;
   logic                    acc_lock_s;
   logic [REG_ADDR_W-1:0]   acc_addr_s;
   logic [REG_DATA_W-1:0]   acc_data_s;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_s)
   );

   // Ready generation and selection of the accepted requester's fields.
   always_comb begin
      owner_mask_s = '0;
      acc_idx_s    = 2'd0;
      acc_lock_s   = 1'b0;
      acc_addr_s   = '0;
      acc_data_s   = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         owner_mask_s[j] = (owner_q == 2'(j));
      end
      if (reset || stall) begin
         req_ready = '0;
      end else if (state_q == BURST) begin
         req_ready = owner_mask_s & req_valid;
      end else begin
         req_ready = pick_s;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         acc_idx_s  = req_ready[j] ? 2'(j) : acc_idx_s;
         acc_lock_s = req_ready[j] ? req_lock[j] : acc_lock_s;
         acc_addr_s = req_ready[j] ? req_addr[j*REG_ADDR_W +: REG_ADDR_W] : acc_addr_s;
         acc_data_s = req_ready[j] ? req_data[j*REG_DATA_W +: REG_DATA_W] : acc_data_s;
      end
      accept_s = |req_ready;
   end

   // Burst FSM, round-robin pointer and burst counter next state.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               rr_ptr_d = wrap_inc(acc_idx_s, NUM_REQ);
               if (acc_lock_s && (BURST_MAX > 1)) begin
                  state_d     = BURST;
                  owner_d     = acc_idx_s;
                  burst_cnt_d = CNT_W'(1);
               end else begin
                  burst_cnt_d = '0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BURST: begin
            if (accept_s) begin
               rr_ptr_d = wrap_inc(acc_idx_s, NUM_REQ);
               if (acc_lock_s && ((burst_cnt_q + CNT_W'(1)) < CNT_MAX)) begin
                  burst_cnt_d = burst_cnt_q + CNT_W'(1);
               end else begin
                  state_d     = IDLE;
                  burst_cnt_d = '0;
               end
            end else if (!stall) begin
               // Owner let go of valid: give up the burst without an accept.
               state_d     = IDLE;
               burst_cnt_d = '0;
            end else begin
               state_d = BURST;
            end
         end
         default: begin
            state_d     = IDLE;
            burst_cnt_d = '0;
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 2'd0;
         rr_ptr_q    <= 2'd0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Registered write port; address-0 writes handshake but never issue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         RegWrite  <= 1'b0;
         WriteAddr <= '0;
         WriteData <= '0;
         grant_id  <= 2'd0;
      end else if (accept_s) begin
         grant_id <= acc_idx_s;
         if ((DROP_ZERO != 0) && (acc_addr_s == '0)) begin
            RegWrite <= 1'b0;
         end else begin
            RegWrite  <= 1'b1;
            WriteAddr <= acc_addr_s;
            WriteData <= acc_data_s;
         end
      end else begin
         RegWrite <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb (NUM_REQ=2, BURST_MAX=4, DROP_ZERO=1).
module tb_regfile_wr_arb;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_lock;
   logic [9:0]  req_addr;
   logic [63:0] req_data;
   logic [1:0]  req_ready;
   logic        stall;
   logic [4:0]  WriteAddr;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [1:0]  grant_id;

   int checks   = 0;
   int failures = 0;

   regfile_wr_arb #(.NUM_REQ(2), .BURST_MAX(4), .DROP_ZERO(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .stall     (stall),
      .WriteAddr (WriteAddr),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .grant_id  (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 2'b00;
      req_lock  = 2'b00;
      req_addr  = 10'd0;
      req_data  = 64'd0;
      stall     = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Drive one cycle, check ready mid-cycle, then check the registered port after the edge.
   task automatic cyc(input string tag, input logic [1:0] v, input logic [1:0] l,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic st,
                      input logic [1:0] e_rdy, input logic e_rw, input logic [1:0] e_gid,
                      input logic [4:0] e_addr, input logic [31:0] e_data);
      req_valid = v;
      req_lock  = l;
      req_addr  = {a1, a0};
      req_data  = {d1, d0};
      stall     = st;
      #3;
      check_eq({tag, ".ready"}, {30'd0, req_ready}, {30'd0, e_rdy});
      @(posedge clk);
      #1;
      check_eq({tag, ".regwrite"}, {31'd0, RegWrite}, {31'd0, e_rw});
      check_eq({tag, ".grant_id"}, {30'd0, grant_id}, {30'd0, e_gid});
      check_eq({tag, ".waddr"}, {27'd0, WriteAddr}, {27'd0, e_addr});
      check_eq({tag, ".wdata"}, WriteData, e_data);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 2'b00;
      req_lock  = 2'b00;
      req_addr  = 10'd0;
      req_data  = 64'd0;
      stall     = 1'b0;
      #2;
      check_eq("rst.ready", {30'd0, req_ready}, 32'd0);
      check_eq("rst.regwrite", {31'd0, RegWrite}, 32'd0);
      check_eq("rst.waddr", {27'd0, WriteAddr}, 32'd0);
      check_eq("rst.wdata", WriteData, 32'd0);
      check_eq("rst.grant_id", {30'd0, grant_id}, 32'd0);

      // Single write, latency one, then hold on idle.
      do_reset();
      cyc("single", 2'b01, 2'b00, 5'd3, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0,
          2'b01, 1'b1, 2'd0, 5'd3, 32'hDEADBEEF);
      cyc("idle", 2'b00, 2'b00, 5'd3, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0,
          2'b00, 1'b0, 2'd0, 5'd3, 32'hDEADBEEF);

      // Round-robin alternation without lock.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) begin
            cyc("alt0", 2'b11, 2'b00, 5'd5, 5'd6, 32'hA0A0A0A0, 32'hB1B1B1B1, 1'b0,
                2'b01, 1'b1, 2'd0, 5'd5, 32'hA0A0A0A0);
         end else begin
            cyc("alt1", 2'b11, 2'b00, 5'd5, 5'd6, 32'hA0A0A0A0, 32'hB1B1B1B1, 1'b0,
                2'b10, 1'b1, 2'd1, 5'd6, 32'hB1B1B1B1);
         end
      end

      // Locked burst capped at four, then req1, then req0.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cyc("burst0", 2'b11, 2'b01, 5'd9, 5'd10, 32'h11111111, 32'h22222222, 1'b0,
             2'b01, 1'b1, 2'd0, 5'd9, 32'h11111111);
      end
      cyc("burst_r1", 2'b11, 2'b01, 5'd9, 5'd10, 32'h11111111, 32'h22222222, 1'b0,
          2'b10, 1'b1, 2'd1, 5'd10, 32'h22222222);
      cyc("burst_r0", 2'b11, 2'b01, 5'd9, 5'd10, 32'h11111111, 32'h22222222, 1'b0,
          2'b01, 1'b1, 2'd0, 5'd9, 32'h11111111);

      // Owner drops valid mid-burst: no accept that cycle, arbitration next cycle.
      do_reset();
      cyc("own_go", 2'b01, 2'b01, 5'd4, 5'd8, 32'h44, 32'h88, 1'b0,
          2'b01, 1'b1, 2'd0, 5'd4, 32'h44);
      cyc("own_drop", 2'b10, 2'b00, 5'd4, 5'd8, 32'h44, 32'h88, 1'b0,
          2'b00, 1'b0, 2'd0, 5'd4, 32'h44);
      cyc("own_after", 2'b10, 2'b00, 5'd4, 5'd8, 32'h44, 32'h88, 1'b0,
          2'b10, 1'b1, 2'd1, 5'd8, 32'h88);

      // Address-0 write is accepted but not issued.
      do_reset();
      cyc("drop0", 2'b10, 2'b00, 5'd0, 5'd0, 32'd0, 32'h1234, 1'b0,
          2'b10, 1'b0, 2'd1, 5'd0, 32'd0);

      // Stall freezes arbitration; order resumes unchanged.
      do_reset();
      cyc("pre_stall", 2'b11, 2'b00, 5'd1, 5'd2, 32'h10, 32'h20, 1'b0,
          2'b01, 1'b1, 2'd0, 5'd1, 32'h10);
      for (int i = 0; i < 3; i++) begin
         cyc("stall", 2'b11, 2'b00, 5'd1, 5'd2, 32'h10, 32'h20, 1'b1,
             2'b00, 1'b0, 2'd0, 5'd1, 32'h10);
      end
      cyc("post_stall1", 2'b11, 2'b00, 5'd1, 5'd2, 32'h10, 32'h20, 1'b0,
          2'b10, 1'b1, 2'd1, 5'd2, 32'h20);
      cyc("post_stall0", 2'b11, 2'b00, 5'd1, 5'd2, 32'h10, 32'h20, 1'b0,
          2'b01, 1'b1, 2'd0, 5'd1, 32'h10);

      // Reset right after an accept discards the pending write.
      do_reset();
      cyc("pre_rst", 2'b01, 2'b00, 5'd7, 5'd0, 32'h77, 32'd0, 1'b0,
          2'b01, 1'b1, 2'd0, 5'd7, 32'h77);
      req_valid = 2'b00;
      reset     = 1'b1;
      #1;
      check_eq("mid_rst.regwrite", {31'd0, RegWrite}, 32'd0);
      check_eq("mid_rst.waddr", {27'd0, WriteAddr}, 32'd0);
      check_eq("mid_rst.wdata", WriteData, 32'd0);
      check_eq("mid_rst.ready", {30'd0, req_ready}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("rst_rel.regwrite", {31'd0, RegWrite}, 32'd0);
      cyc("post_rst", 2'b00, 2'b00, 5'd7, 5'd0, 32'h77, 32'd0, 1'b0,
          2'b00, 1'b0, 2'd0, 5'd0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
